// File: rtl/acc_serialize.sv
// Serializes NUM_PE parallel accumulator lanes into one requantized int8 result per cycle.
// Lane 0 comes out first. A new transfer can be accepted on the last lane so streams run without gaps.
module acc_serialize #(
   parameter int NUM_PE = 4,
   parameter int ACC_W  = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_PE*ACC_W-1:0] in_acc,
   input  logic [4:0]              in_shift,
   input  logic                    in_relu,
   output logic                    out_valid,
   output logic [ACC_W-1:0]        out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
   localparam logic signed [ACC_W:0] ONE    = (ACC_W+1)'(1);
   localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(127);
   localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-128);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [NUM_PE*ACC_W-1:0] cap_acc;
   logic [4:0] cap_shift;
   logic cap_relu;
   logic accept, at_last;

   logic signed [ACC_W-1:0] lane;
   logic [4:0] s_eff;
   logic signed [ACC_W:0] rnd, sum, shr, clipped;
   logic [ACC_W-1:0] requant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // On the last lane the block is ready again, so a waiting transfer follows without a bubble.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      at_last   = (idx == LAST_IDX);
      in_ready  = (state == IDLE) || at_last;
      accept    = in_valid && in_ready;
      busy      = (state == SHIFT);
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SHIFT;
               idx_nxt   = '0;
            end
         end
         SHIFT: begin
            if (at_last) begin
               idx_nxt   = '0;
               state_nxt = accept ? SHIFT : IDLE;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // The sum is one bit wider than the accumulator, so adding the rounding term cannot overflow.
   always_comb begin
      lane = cap_acc[int'(idx)*ACC_W +: ACC_W];
      if (int'(cap_shift) > ACC_W - 1) s_eff = 5'(ACC_W - 1);
      else                             s_eff = cap_shift;
      rnd = '0;
      if (s_eff != 5'd0) rnd = ONE << (s_eff - 5'd1);
      sum = {lane[ACC_W-1], lane} + rnd;
      shr = sum >>> s_eff;
      if (cap_relu && shr[ACC_W]) shr = '0;
      if (shr > SAT_HI)      clipped = SAT_HI;
      else if (shr < SAT_LO) clipped = SAT_LO;
      else                   clipped = shr;
      requant = {{(ACC_W-8){clipped[7]}}, clipped[7:0]};
   end

   // Capture and emission registers. The lane emitted this cycle always comes from the old capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_acc   <= '0;
         cap_shift <= '0;
         cap_relu  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         if (accept) begin
            cap_acc   <= in_acc;
            cap_shift <= in_shift;
            cap_relu  <= in_relu;
         end
         out_valid <= (state == SHIFT);
         out_last  <= (state == SHIFT) && at_last;
         out_data  <= (state == SHIFT) ? requant : '0;
      end
   end

endmodule

// File: tb/tb_acc_serialize.sv
// Directed self-checking bench for acc_serialize (NUM_PE=4, ACC_W=24).
// The expected results were computed by hand.
module tb_acc_serialize;

   logic clk, rst, in_valid, in_ready, in_relu;
   logic [95:0] in_acc;
   logic [4:0] in_shift;
   logic out_valid, out_last, busy;
   logic [23:0] out_data;
   int tests_run = 0;
   int failures = 0;

   acc_serialize #(.NUM_PE(4), .ACC_W(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_acc(in_acc), .in_shift(in_shift), .in_relu(in_relu),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [95:0] pack(input logic [23:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   // Presents one transfer in IDLE and returns 1 time unit after the accepting edge.
   task automatic start_transfer(input logic [95:0] acc, input logic [4:0] sh, input logic relu);
      in_valid = 1'b1; in_acc = acc; in_shift = sh; in_relu = relu;
      @(posedge clk); #1;
      in_valid = 1'b0; in_acc = '0; in_shift = '0; in_relu = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 24'h0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset: valid=%b last=%b busy=%b data=%h ready=%b, required 0 0 0 000000 1",
                  out_valid, out_last, busy, out_data, in_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [23:0] exp_d [4] = '{24'h000064, 24'hFFFF9C, 24'h00007F, 24'hFFFF80};
      start_transfer(pack(24'd100, -24'd100, 24'd300, -24'd300), 5'd0, 1'b0);
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_accept: busy=%b ready=%b valid=%b, required 1 0 0", busy, in_ready, out_valid);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL single_lane%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d[k], (k == 3));
         end
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL single_end: valid=%b last=%b busy=%b ready=%b, required 0 0 0 1",
                  out_valid, out_last, busy, in_ready);
      end
   endtask

   task automatic test_rounding();
      logic [23:0] exp_d [4] = '{24'h000002, 24'h000001, 24'hFFFFFF, 24'hFFFFFF};
      start_transfer(pack(24'd6, 24'd5, -24'd6, -24'd5), 5'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL rounding_lane%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d[k], (k == 3));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_relu();
      logic [23:0] exp_d [4] = '{24'h000000, 24'h000032, 24'h000000, 24'h00007F};
      start_transfer(pack(-24'd50, 24'd50, -24'd1, 24'h7FFFFF), 5'd0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL relu_lane%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d[k], (k == 3));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_shift_clamp();
      logic [23:0] exp_d [4] = '{24'hFFFFFF, 24'h000001, 24'h000000, 24'h000000};
      start_transfer(pack(24'h800000, 24'h7FFFFF, 24'h000000, 24'hFFFFFF), 5'd31, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k]) begin
            failures++;
            $display("[TB] FAIL clamp_lane%0d: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp_d[k]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp_d [8] = '{24'h00000A, 24'h000014, 24'h00001E, 24'h000028,
                                 24'h000001, 24'hFFFFFF, 24'h000002, 24'hFFFFFE};
      in_valid = 1'b1; in_acc = pack(24'd10, 24'd20, 24'd30, 24'd40); in_shift = 5'd0; in_relu = 1'b0;
      @(posedge clk); #1;
      in_acc = pack(24'd4, -24'd4, 24'd8, -24'd8); in_shift = 5'd2;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 3 || k == 7)) begin
            failures++;
            $display("[TB] FAIL b2b_out%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d[k], (k == 3 || k == 7));
         end
         if (k == 0 || k == 2) begin
            tests_run++;
            if (in_ready !== (k == 2)) begin
               failures++;
               $display("[TB] FAIL b2b_ready%0d: ready=%b, required %b", k, in_ready, (k == 2));
            end
         end
         if (k == 3) in_valid = 1'b0;
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_end: valid=%b busy=%b, required 0 0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [23:0] exp_d [4] = '{24'hFFFFFD, 24'h000004, 24'h00007F, 24'hFFFF80};
      bit seen_bad;
      start_transfer(pack(24'd11, 24'd22, 24'd33, 24'd44), 5'd0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== 24'(11 * (k + 1))) begin
            failures++;
            $display("[TB] FAIL abort_lane%0d: valid=%b data=%h, required 1 %h", k, out_valid, out_data, 24'(11 * (k + 1)));
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 24'h0) begin
         failures++;
         $display("[TB] FAIL abort_reset: valid=%b last=%b busy=%b ready=%b data=%h, required 0 0 0 1 000000",
                  out_valid, out_last, busy, in_ready, out_data);
      end
      seen_bad = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || out_last !== 1'b0) seen_bad = 1'b1;
      end
      tests_run++;
      if (seen_bad !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_quiet: leftover output seen=%b, required 0", seen_bad);
      end
      start_transfer(pack(-24'd7, 24'd8, 24'd1000, -24'd1000), 5'd1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL fresh_lane%0d: valid=%b data=%h last=%b, required 1 %h %b",
                     k, out_valid, out_data, out_last, exp_d[k], (k == 3));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; in_valid = 1'b1; in_acc = pack(24'd1, 24'd2, 24'd3, 24'd4); in_shift = 5'd0;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL prio_state: busy=%b ready=%b, required 0 1", busy, in_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL prio_dropped: valid=%b busy=%b, required 0 0", out_valid, busy);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_acc = '0; in_shift = '0; in_relu = 1'b0;
      test_reset();
      test_single();
      test_rounding();
      test_relu();
      test_shift_clamp();
      test_back_to_back();
      test_reset_mid_shift();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
